// File: rtl/ps2_host_tx_ctrl_pkg.sv
// Shared definitions for the PS/2 host-to-device transmit controller:
// state encoding, frame layout, default timing and mouse command bytes.
package ps2_host_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_IDLE = 3'd5
    } tx_state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_LEN = 11;

    // Defaults assume a 100 MHz CLK
    localparam int DEF_INHIBIT_CYCLES  = 10000;
    localparam int DEF_REQ_HOLD_CYCLES = 2000;
    localparam int DEF_TIMEOUT_CYCLES  = 1500000;
    localparam int DEF_TIMER_WIDTH     = 21;

    localparam logic [7:0] CMD_RESET            = 8'hFF;
    localparam logic [7:0] CMD_ENABLE_REPORTING = 8'hF4;
    localparam logic [7:0] RSP_ACK              = 8'hFA;

    // Frame as it goes on the wire, bit 0 first: start(0), D0..D7, odd parity, stop(1)
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_host_tx_ctrl_if.sv
// Command/pad bundle between the mouse command FSM, the pad tristate logic
// and the PS/2 transmit controller.
interface ps2_host_tx_ctrl_if;

    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       PS2_CLK_IN;
    logic       PS2_DATA_IN;
    logic       PS2_CLK_OUT_EN;
    logic       PS2_DATA_OUT_EN;
    logic       BUSY;
    logic       RX_INHIBIT;
    logic       BYTE_SENT;
    logic       ERROR;

    // Command issuer and pad side
    modport master (
        output SEND_BYTE, BYTE_TO_SEND, PS2_CLK_IN, PS2_DATA_IN,
        input  PS2_CLK_OUT_EN, PS2_DATA_OUT_EN, BUSY, RX_INHIBIT, BYTE_SENT, ERROR
    );

    // Transmit controller side
    modport slave (
        input  SEND_BYTE, BYTE_TO_SEND, PS2_CLK_IN, PS2_DATA_IN,
        output PS2_CLK_OUT_EN, PS2_DATA_OUT_EN, BUSY, RX_INHIBIT, BYTE_SENT, ERROR
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer and falling-edge detector for one PS/2 pad line.
// Flops reset to the idle-high level so reset release never fakes an edge.
module ps2_line_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic line_in,
    output logic line_sync,
    output logic line_fall
);

    logic meta_p0;
    logic sync_p1;
    logic prev_p2;

    // Synchronize the asynchronous pad and keep one cycle of history
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            meta_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            prev_p2 <= 1'b1;
        end else begin
            meta_p0 <= line_in;
            sync_p1 <= meta_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign line_sync = sync_p1;
    assign line_fall = prev_p2 & ~sync_p1;

endmodule

// File: rtl/ps2_host_tx_ctrl.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request to
// send, then shifts one command byte out on device clock falling edges and
// checks the device acknowledge. Falling edges are timed out while waiting
// on the device.
module ps2_host_tx_ctrl
    import ps2_host_tx_ctrl_pkg::*;
#(
    parameter int INHIBIT_CYCLES  = DEF_INHIBIT_CYCLES,
    parameter int REQ_HOLD_CYCLES = DEF_REQ_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int TIMER_WIDTH     = DEF_TIMER_WIDTH
) (
    input  logic         CLK,
    input  logic         RESET,
    ps2_host_tx_ctrl_if.slave bus
);

    // Timer compare points: phase timers end on the last cycle of the phase,
    // the device timeout fires once the count reaches the limit.
    localparam logic [TIMER_WIDTH-1:0] INHIBIT_LAST = TIMER_WIDTH'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] REQ_LAST     = TIMER_WIDTH'(REQ_HOLD_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_VAL  = TIMER_WIDTH'(TIMEOUT_CYCLES);
    // bit_cnt value seen on the tenth (stop bit) edge
    localparam logic [3:0]             LAST_EDGE    = 4'd9;

    tx_state_t                state_q, state_d;
    logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
    logic [TIMER_WIDTH-1:0]   timer_inc;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    logic [FRAME_LEN-1:0]     frame_q, frame_d;
    logic                     data_low_q, data_low_d;
    logic                     timed_out;
    logic                     byte_sent;
    logic                     error;
    logic                     busy;

    logic                     clk_sync;
    logic                     clk_fall;
    logic                     data_sync;
    logic                     data_fall_unused;

    ps2_line_sync u_clk_sync (
        .CLK       (CLK),
        .RESET     (RESET),
        .line_in   (bus.PS2_CLK_IN),
        .line_sync (clk_sync),
        .line_fall (clk_fall)
    );

    // The data line is only sampled on clock edges, its own edges are not needed here
    ps2_line_sync u_data_sync (
        .CLK       (CLK),
        .RESET     (RESET),
        .line_in   (bus.PS2_DATA_IN),
        .line_sync (data_sync),
        .line_fall (data_fall_unused)
    );

    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    assign timed_out = (timer_q == TIMEOUT_VAL);

    // State, timer, bit counter, frame shifter and driven data level
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            data_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            data_low_q <= data_low_d;
        end
    end

    // Next-state, timer control and result pulses
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        data_low_d = data_low_q;
        byte_sent  = 1'b0;
        error      = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d    = '0;
                bit_cnt_d  = '0;
                data_low_d = 1'b0;
                if (bus.SEND_BYTE) begin
                    frame_d = build_frame(bus.BYTE_TO_SEND);
                    state_d = INHIBIT;
                end
            end

            // Device clock edges here are our own drive or glitches: ignored
            INHIBIT: begin
                if (timer_q == INHIBIT_LAST) begin
                    timer_d = '0;
                    state_d = REQ;
                end else begin
                    timer_d = timer_inc;
                end
            end

            REQ: begin
                if (timer_q == REQ_LAST) begin
                    timer_d    = '0;
                    bit_cnt_d  = '0;
                    data_low_d = 1'b1;
                    frame_d    = frame_q >> 1;
                    state_d    = SEND;
                end else begin
                    timer_d = timer_inc;
                end
            end

            // An edge in the same cycle as expiry is still honoured
            SEND: begin
                if (clk_fall) begin
                    timer_d    = '0;
                    data_low_d = ~frame_q[0];
                    frame_d    = frame_q >> 1;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_EDGE) begin
                        state_d = WAIT_ACK;
                    end
                end else if (timed_out) begin
                    error      = 1'b1;
                    data_low_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end

            WAIT_ACK: begin
                data_low_d = 1'b0;
                if (clk_fall) begin
                    timer_d = '0;
                    if (!data_sync) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        error   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (timed_out) begin
                    error   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end

            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    byte_sent = 1'b1;
                    state_d   = IDLE;
                end else if (clk_fall) begin
                    timer_d = '0;
                end else if (timed_out) begin
                    error   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy                = (state_q != IDLE);
    assign bus.BUSY            = busy;
    assign bus.RX_INHIBIT      = busy;
    assign bus.BYTE_SENT       = byte_sent;
    assign bus.ERROR           = error;
    assign bus.PS2_CLK_OUT_EN  = (state_q == INHIBIT) || (state_q == REQ);
    assign bus.PS2_DATA_OUT_EN = (state_q == REQ) || ((state_q == SEND) && data_low_q);

endmodule

// File: tb/tb_ps2_host_tx_ctrl.sv
// Bench for ps2_host_tx_ctrl with shortened timing: an open-drain bus model,
// a PS/2 device model that clocks frames, and a queue of expected wire bits.
module tb_ps2_host_tx_ctrl;
    import ps2_host_tx_ctrl_pkg::*;

    localparam int INH_C  = 100;
    localparam int REQH_C = 20;
    localparam int TMO_C  = 400;
    localparam int HALF   = 8;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;

    int errors = 0;
    int checks = 0;
    int sent_cnt = 0;
    int err_cnt = 0;
    int pulse_bad = 0;
    int inh_bad = 0;
    logic prev_sent = 1'b0;
    logic prev_err = 1'b0;
    logic exp_q[$];

    ps2_host_tx_ctrl_if bus();

    // Open-drain lines: anyone driving low wins
    assign bus.PS2_CLK_IN  = bus.PS2_CLK_OUT_EN  ? 1'b0 : dev_clk;
    assign bus.PS2_DATA_IN = bus.PS2_DATA_OUT_EN ? 1'b0 : dev_data;

    ps2_host_tx_ctrl #(
        .INHIBIT_CYCLES  (INH_C),
        .REQ_HOLD_CYCLES (REQH_C),
        .TIMEOUT_CYCLES  (TMO_C),
        .TIMER_WIDTH     (21)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Pulse bookkeeping: counts, one-cycle width, exclusivity, BUSY framing
    always @(negedge CLK) begin
        if (bus.BYTE_SENT === 1'b1) sent_cnt <= sent_cnt + 1;
        if (bus.ERROR === 1'b1) err_cnt <= err_cnt + 1;
        if ((bus.BYTE_SENT && bus.ERROR) || ((bus.BYTE_SENT || bus.ERROR) && !bus.BUSY) ||
            (prev_sent && bus.BYTE_SENT) || (prev_err && bus.ERROR) ||
            ((prev_sent || prev_err) && bus.BUSY))
            pulse_bad <= pulse_bad + 1;
        if (bus.RX_INHIBIT !== bus.BUSY) inh_bad <= inh_bad + 1;
        prev_sent <= bus.BYTE_SENT;
        prev_err  <= bus.ERROR;
    end

    task automatic send_cmd(input logic [7:0] b);
        @(posedge CLK); #1;
        bus.SEND_BYTE = 1'b1;
        bus.BYTE_TO_SEND = b;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(~^b);
        exp_q.push_back(1'b1);
        @(posedge CLK); #1;
        bus.SEND_BYTE = 1'b0;
    endtask

    task automatic measure_request(output int n_inh, output int n_req);
        n_inh = 0;
        n_req = 0;
        for (int i = 0; i < INH_C + REQH_C + 20; i++) begin
            @(negedge CLK);
            if (bus.PS2_CLK_OUT_EN && !bus.PS2_DATA_OUT_EN) n_inh++;
            else if (bus.PS2_CLK_OUT_EN && bus.PS2_DATA_OUT_EN) n_req++;
            else if (n_req > 0) break;
        end
    endtask

    // Device model: sample start bit, then clock n edges sampling after each rise
    task automatic dev_bits(input int n_edges);
        logic got, want;
        repeat (HALF) @(negedge CLK);
        for (int n = 0; n <= n_edges; n++) begin
            if (n > 0) begin
                dev_clk = 1'b0;
                repeat (HALF) @(negedge CLK);
                dev_clk = 1'b1;
                repeat (HALF) @(negedge CLK);
            end
            got = bus.PS2_DATA_IN;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_bit[%0d]: sampled %b but no bit was expected", n, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL frame_bit[%0d]: sampled %b expected %b", n, got, want);
                end
            end
        end
    endtask

    task automatic dev_ack(input logic level);
        dev_data = level;
        repeat (4) @(negedge CLK);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge CLK);
        dev_clk = 1'b1;
        repeat (HALF) @(negedge CLK);
        dev_data = 1'b1;
    endtask

    task automatic wait_result(input int s0, input int e0, output logic expired);
        int guard = 0;
        while (sent_cnt == s0 && err_cnt == e0 && guard < 40) begin
            @(negedge CLK);
            guard++;
        end
        expired = (guard >= 40);
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_reset;
        int bad = 0;
        RESET = 1'b0;
        repeat (5) @(negedge CLK);
        checks++;
        if ({bus.PS2_CLK_OUT_EN, bus.PS2_DATA_OUT_EN, bus.BUSY, bus.RX_INHIBIT,
             bus.BYTE_SENT, bus.ERROR} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {bus.PS2_CLK_OUT_EN, bus.PS2_DATA_OUT_EN, bus.BUSY, bus.RX_INHIBIT,
                      bus.BYTE_SENT, bus.ERROR});
        end
        RESET = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (bus.BUSY || bus.PS2_CLK_OUT_EN || bus.PS2_DATA_OUT_EN || bus.BYTE_SENT || bus.ERROR)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_hold: %0d active cycles, expected 0", bad);
        end
    endtask

    task automatic test_send_f4;
        int n_inh, n_req, s0, e0;
        logic expired;
        s0 = sent_cnt;
        e0 = err_cnt;
        send_cmd(CMD_ENABLE_REPORTING);
        checks++;
        if (bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept: got %b expected 1", bus.BUSY);
        end
        measure_request(n_inh, n_req);
        checks++;
        if (n_inh !== INH_C) begin
            errors++;
            $display("FAIL inhibit_len: got %0d cycles expected %0d", n_inh, INH_C);
        end
        checks++;
        if (n_req !== REQH_C) begin
            errors++;
            $display("FAIL request_len: got %0d cycles expected %0d", n_req, REQH_C);
        end
        checks++;
        if (bus.PS2_DATA_OUT_EN !== 1'b1 || bus.PS2_CLK_OUT_EN !== 1'b0) begin
            errors++;
            $display("FAIL send_entry: clk_en=%b data_en=%b expected 0/1",
                     bus.PS2_CLK_OUT_EN, bus.PS2_DATA_OUT_EN);
        end
        dev_bits(10);
        dev_ack(1'b0);
        wait_result(s0, e0, expired);
        checks++;
        if (expired || sent_cnt - s0 !== 1 || err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL f4_outcome: sent=%0d err=%0d expected sent=1 err=0",
                     sent_cnt - s0, err_cnt - e0);
        end
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL f4_busy_end: got %b expected 0", bus.BUSY);
        end
    endtask

    task automatic test_send_ff;
        int n_inh, n_req, s0, e0;
        logic expired;
        s0 = sent_cnt;
        e0 = err_cnt;
        send_cmd(CMD_RESET);
        measure_request(n_inh, n_req);
        dev_bits(10);
        dev_ack(1'b0);
        wait_result(s0, e0, expired);
        checks++;
        if (expired || sent_cnt - s0 !== 1 || err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL ff_outcome: sent=%0d err=%0d expected sent=1 err=0",
                     sent_cnt - s0, err_cnt - e0);
        end
    endtask

    task automatic test_timeout;
        int n_inh, n_req, k, e0;
        e0 = err_cnt;
        send_cmd(8'h55);
        measure_request(n_inh, n_req);
        k = 0;
        while (bus.ERROR !== 1'b1 && k < TMO_C + 50) begin
            @(negedge CLK);
            k++;
        end
        checks++;
        if (k < TMO_C || k > TMO_C + 3) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d expected %0d..%0d", k, TMO_C, TMO_C + 3);
        end
        @(negedge CLK);
        checks++;
        if (bus.PS2_CLK_OUT_EN !== 1'b0 || bus.PS2_DATA_OUT_EN !== 1'b0 || bus.BUSY !== 1'b0 ||
            err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL timeout_release: clk_en=%b data_en=%b busy=%b errs=%0d expected 0/0/0/1",
                     bus.PS2_CLK_OUT_EN, bus.PS2_DATA_OUT_EN, bus.BUSY, err_cnt - e0);
        end
        exp_q.delete();
    endtask

    task automatic test_no_ack;
        int n_inh, n_req, s0, e0;
        logic expired;
        s0 = sent_cnt;
        e0 = err_cnt;
        send_cmd(8'h3C);
        measure_request(n_inh, n_req);
        dev_bits(10);
        dev_ack(1'b1);
        wait_result(s0, e0, expired);
        checks++;
        if (expired || sent_cnt - s0 !== 0 || err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL no_ack_outcome: sent=%0d err=%0d expected sent=0 err=1",
                     sent_cnt - s0, err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid;
        int n_inh, n_req, s0, e0;
        logic expired;
        s0 = sent_cnt;
        e0 = err_cnt;
        send_cmd(8'hA5);
        measure_request(n_inh, n_req);
        dev_bits(4);
        dev_clk = 1'b0;
        repeat (5) @(negedge CLK);
        checks++;
        if (bus.PS2_DATA_OUT_EN !== 1'b0 ^ 1'b1) begin
            errors++;
            $display("FAIL bit4_drive: data_en=%b expected 1", bus.PS2_DATA_OUT_EN);
        end
        @(posedge CLK); #2;
        RESET = 1'b0;
        #1;
        checks++;
        if (bus.PS2_CLK_OUT_EN !== 1'b0 || bus.PS2_DATA_OUT_EN !== 1'b0 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: clk_en=%b data_en=%b busy=%b expected 0/0/0",
                     bus.PS2_CLK_OUT_EN, bus.PS2_DATA_OUT_EN, bus.BUSY);
        end
        dev_clk = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (sent_cnt - s0 !== 0 || err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL abort_pulses: sent=%0d err=%0d expected 0/0", sent_cnt - s0, err_cnt - e0);
        end
        exp_q.delete();
        // Follow-up transfer, with a request issued while busy that must be dropped
        send_cmd(CMD_ENABLE_REPORTING);
        @(negedge CLK);
        bus.SEND_BYTE = 1'b1;
        bus.BYTE_TO_SEND = 8'h00;
        @(negedge CLK);
        bus.SEND_BYTE = 1'b0;
        measure_request(n_inh, n_req);
        dev_bits(10);
        dev_ack(1'b0);
        wait_result(s0, e0, expired);
        checks++;
        if (expired || sent_cnt - s0 !== 1 || err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL after_reset_outcome: sent=%0d err=%0d expected 1/0",
                     sent_cnt - s0, err_cnt - e0);
        end
        repeat (50) @(negedge CLK);
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignored_req: busy=%b expected 0", bus.BUSY);
        end
    endtask

    task automatic test_pulse_rules;
        checks++;
        if (pulse_bad !== 0) begin
            errors++;
            $display("FAIL pulse_rules: %0d violations expected 0", pulse_bad);
        end
        checks++;
        if (inh_bad !== 0) begin
            errors++;
            $display("FAIL rx_inhibit_eq_busy: %0d cycles differ expected 0", inh_bad);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bits left expected 0", exp_q.size());
        end
    endtask

    initial begin
        bus.SEND_BYTE = 1'b0;
        bus.BYTE_TO_SEND = 8'h00;
        test_reset();
        test_send_f4();
        test_send_ff();
        test_timeout();
        test_no_ack();
        test_reset_mid();
        test_pulse_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx_ctrl.md
Name: ps2_host_tx_ctrl

Overview:
Host-to-device PS/2 transmit controller for the mouse interface. It sequences the open-drain PS/2 clock and data lines to send one command byte to the mouse, e.g. 0xFF reset or 0xF4 enable reporting. Internal cycle timers time the inhibit and request phases. It sits between the mouse init/command FSM and the pad tristate logic, and flags the receive path to ignore the line while transmitting.

Parameters:
INHIBIT_CYCLES, 10000, CLK cycles PS2 clock is held low before the request (100 us at 100 MHz)
REQ_HOLD_CYCLES, 2000, CLK cycles clock and data are both held low before the clock is released (20 us)
TIMEOUT_CYCLES, 1500000, maximum CLK cycles between consecutive device clock falling edges while waiting on the device (15 ms)
TIMER_WIDTH, 21, width of the internal cycle timer; must hold TIMEOUT_CYCLES

Ports:
CLK  input  1  system clock; only clock domain
RESET  input  1  asynchronous, active-low reset (0 = reset)
SEND_BYTE  input  1  single-cycle request; accepted only when BUSY=0
BYTE_TO_SEND  input  8  command byte; captured on the accepting cycle
PS2_CLK_IN  input  1  raw PS/2 clock pad input (asynchronous)
PS2_DATA_IN  input  1  raw PS/2 data pad input (asynchronous)
PS2_CLK_OUT_EN  output  1  1 = drive PS/2 clock low; 0 = release
PS2_DATA_OUT_EN  output  1  1 = drive PS/2 data low; 0 = release
BUSY  output  1  high from the accepting cycle until DONE/ERROR returns to IDLE
RX_INHIBIT  output  1  equals BUSY; receive path ignores the line while high
BYTE_SENT  output  1  one-cycle pulse: device acknowledged and the bus returned idle
ERROR  output  1  one-cycle pulse: timeout or missing ack; byte aborted

Behaviour:
- Reset (RESET=0, async): state=IDLE; all outputs 0; lines released; timer, bit count and shift register cleared. Assertion mid-transfer aborts immediately, with no BYTE_SENT or ERROR pulse.
- Input sync: PS2_CLK_IN and PS2_DATA_IN each pass through 2 flops. A falling edge is prev_sync=1 and sync=0, giving 3 CLK cycles of latency from the pad.
- Capture: when IDLE and SEND_BYTE=1, latch the 11-bit frame {stop=1, parity=~^BYTE_TO_SEND (odd), byte LSB-first}. The start bit is implicit. SEND_BYTE is ignored while BUSY=1.
- IDLE: outputs released, BUSY=0. On accept, go to INHIBIT; BUSY rises on the next edge.
- INHIBIT: CLK_OUT_EN=1, DATA_OUT_EN=0, for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ: CLK_OUT_EN=1, DATA_OUT_EN=1 (start bit 0), for exactly REQ_HOLD_CYCLES cycles, then go to SEND.
- SEND: CLK_OUT_EN=0 and the start bit stays driven. On each synchronized falling edge n (1..10), drive frame bit n-1: DATA_OUT_EN = ~bit.
  - Edges 1..8 carry D0..D7, edge 9 carries parity, edge 10 carries stop (line released).
  - After edge 10, go to WAIT_ACK.
- WAIT_ACK: lines released. On the next falling edge, sample data_sync.
  - 0 = ack: go to WAIT_IDLE.
  - 1 = no ack: pulse ERROR and go to IDLE.
- WAIT_IDLE: when clk_sync=1 and data_sync=1 in the same cycle, pulse BYTE_SENT and go to IDLE.
- Timeout: in SEND, WAIT_ACK and WAIT_IDLE, the timer restarts on every falling edge (and on WAIT_IDLE entry). When it reaches TIMEOUT_CYCLES: release both lines, pulse ERROR, go to IDLE.
- Timer: counts up from 0 and saturates; compares are equality against parameters (no wrap).
- Bit counter: 4 bits, range 0..10, cleared on entry to SEND.
- Edge cases:
  - An edge arriving in the same cycle the timer expires: the edge wins.
  - Falling edges seen during INHIBIT/REQ (device glitch) are ignored.
- Pulse rules: BYTE_SENT and ERROR are mutually exclusive and last exactly 1 cycle. SEND_BYTE in the same cycle as either pulse is ignored, because BUSY is still 1.

Decomposition:
- Shared package: state encoding (IDLE, INHIBIT, REQ, SEND, WAIT_ACK, WAIT_IDLE), frame length 11, default cycle constants, command byte constants (0xFF, 0xF4, ack 0xFA).
- Sub-module ps2_line_sync: 2-flop synchronizer plus falling-edge detector for one line, instantiated twice. It is reusable by the receive path.

Test Plan:
1. Reset with PS2 lines high, then release RESET -> all outputs 0, BUSY=0; SEND_BYTE held 0 keeps state IDLE for 100 cycles.
2. SEND_BYTE with 0xF4 -> CLK_OUT_EN high for exactly 10000 cycles, then both enables high for 2000 cycles. A device model clocks 11 edges and samples data 0,0,0,1,0,1,1,1,1,0(parity),1(stop), then drives ack low -> one BYTE_SENT pulse, BUSY falls the same cycle as IDLE entry.
3. Send 0xFF -> parity bit sampled as 1; ERROR never asserts.
4. Device releases clock but never clocks -> ERROR pulses exactly TIMEOUT_CYCLES after SEND entry (plus sync latency tolerance 3); both enables 0.
5. Device clocks 11 edges but leaves data high at the ack edge -> ERROR pulse, no BYTE_SENT.
6. Assert RESET at bit edge 5 -> enables drop asynchronously within the same cycle; the next SEND_BYTE after release completes normally. A SEND_BYTE issued while BUSY=1 is ignored: the frame on the bus is unchanged.
